des128_key_sched_ctrl: RTL and testbench

Sequences the 128-bit expanded-DES key schedule: it latches a key as two 64-bit halves (C, D) and steps them through 16 rounds.
Each round applies the per-round rotation and presents that round's C/D pair to the round-key compression stage over a valid/ready handshake.
It supports encrypt order (rotate left, rounds 1..16) and decrypt order (reverse schedule, rotate right).
It sits between the key input path and the round datapath, replacing free-running C0/D0 register staging with a controlled, back-pressurable sequence.

---
 rtl/des128_key_sched_ctrl_pkg.sv | 24 ++
 rtl/des128_key_sched_ctrl_if.sv | 28 ++
 rtl/des128_key_sched_ctrl_half_rotator.sv | 18 +
 rtl/des128_key_sched_ctrl.sv | 86 ++++++++
 tb/tb_des128_key_sched_ctrl.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/des128_key_sched_ctrl_pkg.sv
// Shared constants, state encoding and per-round shift lookup for the
// 128-bit DES key schedule controller.
package des128_pkg;

  localparam int HALF_W     = 64;
  localparam int NUM_ROUNDS = 16;
  localparam int IDX_W      = 5;
  localparam int AMT_W      = $clog2(HALF_W);

  localparam logic [NUM_ROUNDS-1:0] SHIFT_MASK = 16'h8103;
  localparam int TOTAL_SHIFT = 2 * NUM_ROUNDS - $countones(SHIFT_MASK);

  typedef enum logic { IDLE, ROUND } state_t;
  typedef enum logic { ROT_LEFT, ROT_RIGHT } rot_dir_t;

  // Rotation applied to reach round r (1-based); r outside 1..16 aliases a
  // valid entry and is only ever looked up on a path whose result is unused.
  function automatic logic [AMT_W-1:0] shift_amt(input logic [IDX_W-1:0] r);
    logic [$clog2(NUM_ROUNDS)-1:0] bit_i;
    bit_i = ($clog2(NUM_ROUNDS))'(r - 5'd1);
    return SHIFT_MASK[bit_i] ? AMT_W'(1) : AMT_W'(2);
  endfunction

endpackage

// File: rtl/des128_key_sched_ctrl_if.sv
// Key-load and round-pair handshake bundle between the key path, the
// schedule controller and the round-key compression stage.
interface des128_key_sched_ctrl_if;
  import des128_pkg::*;

  logic              start;
  logic              decrypt;
  logic [HALF_W-1:0] key_c;
  logic [HALF_W-1:0] key_d;
  logic              round_ready;
  logic              round_valid;
  logic [IDX_W-1:0]  round_idx;
  logic [HALF_W-1:0] C_out;
  logic [HALF_W-1:0] D_out;
  logic              busy;
  logic              done;

  modport master (
    output start, decrypt, key_c, key_d, round_ready,
    input  round_valid, round_idx, C_out, D_out, busy, done
  );

  modport slave (
    input  start, decrypt, key_c, key_d, round_ready,
    output round_valid, round_idx, C_out, D_out, busy, done
  );

endinterface

// File: rtl/des128_key_sched_ctrl_half_rotator.sv
// Combinational rotate of one key half, left or right by a small amount.
module des128_half_rotator
  import des128_pkg::*;
(
  input  logic [HALF_W-1:0] din,
  input  rot_dir_t          dir,
  input  logic [AMT_W-1:0]  amount,
  output logic [HALF_W-1:0] dout
);

  logic [AMT_W:0] inv_amt;

  assign inv_amt = (AMT_W+1)'(HALF_W) - {1'b0, amount};

  assign dout = (dir == ROT_LEFT) ? ((din << amount) | (din >> inv_amt))
                                  : ((din >> amount) | (din << inv_amt));

endmodule

// File: rtl/des128_key_sched_ctrl.sv
// Steps the C/D key halves through 16 rounds in encrypt or decrypt order,
// presenting each round pair over a back-pressurable valid/ready handshake.
module des128_key_sched_ctrl
  import des128_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset,
  des128_key_sched_ctrl_if.slave  bus
);

  state_t            state;
  logic              dec_q;
  logic [HALF_W-1:0] src_c, src_d, rot_c, rot_d;
  rot_dir_t          dir;
  logic [AMT_W-1:0]  amt;
  logic              fire;

  assign fire = bus.round_valid && bus.round_ready;

  // In IDLE the rotators load the fresh key; in ROUND they advance the pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    src_c = bus.C_out;
    src_d = bus.D_out;
    dir   = ROT_LEFT;
    amt   = shift_amt(bus.round_idx + 5'd1);
    if (state == IDLE) begin
      src_c = bus.key_c;
      src_d = bus.key_d;
      amt   = bus.decrypt ? AMT_W'(TOTAL_SHIFT) : shift_amt(5'd1);
    end else if (dec_q) begin
      dir = ROT_RIGHT;
      amt = shift_amt(5'd17 - bus.round_idx);
    end
  end

  des128_half_rotator u_rot_c (.din(src_c), .dir(dir), .amount(amt), .dout(rot_c));
  des128_half_rotator u_rot_d (.din(src_d), .dir(dir), .amount(amt), .dout(rot_d));

  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
    if (Reset) begin
      state           <= IDLE;
      dec_q           <= 1'b0;
      bus.round_valid <= 1'b0;
      bus.round_idx   <= '0;
      bus.C_out       <= '0;
      bus.D_out       <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state           <= ROUND;
            dec_q           <= bus.decrypt;
            bus.round_valid <= 1'b1;
            bus.round_idx   <= 5'd1;
            bus.busy        <= 1'b1;
            bus.C_out       <= rot_c;
            bus.D_out       <= rot_d;
          end
        end
        ROUND: begin
          if (fire) begin
            if (bus.round_idx == IDX_W'(NUM_ROUNDS)) begin
              state           <= IDLE;
              bus.round_valid <= 1'b0;
              bus.round_idx   <= '0;
              bus.busy        <= 1'b0;
              bus.done        <= 1'b1;
            end else begin
              bus.round_idx <= bus.round_idx + 5'd1;
              bus.C_out     <= rot_c;
              bus.D_out     <= rot_d;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des128_key_sched_ctrl.sv
// Directed bench for the DES key schedule controller: encrypt, decrypt,
// back-pressure, mid-run reset, ignored start and back-to-back schedules.
module tb_des128_key_sched_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  // Cumulative left rotation of the encrypt pair at each round, by hand.
  int cum [1:16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  des128_key_sched_ctrl_if bus ();

  des128_key_sched_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // Outputs settle 1 time unit after the edge; inputs change there too.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_sched(input bit dec, input logic [63:0] kc, input logic [63:0] kd);
    bus.start   = 1'b1;
    bus.decrypt = dec;
    bus.key_c   = kc;
    bus.key_d   = kd;
    step();
    bus.start = 1'b0;
  endtask

  // Called one cycle after start: walks rounds 1..16 and checks the done pulse.
  task automatic run(input bit dec, input logic [63:0] kc, input logic [63:0] kd,
                     input int stall_at, input bit poke_at3);
    logic [63:0] exp_c, exp_d;
    int          k;
    for (int r = 1; r <= 16; r++) begin
      k     = dec ? cum[17 - r] : cum[r];
      exp_c = rotl64(kc, k);
      exp_d = rotl64(kd, k);
      check($sformatf("idx r%0d", r), 64'(bus.round_idx), 64'(r));
      check($sformatf("valid r%0d", r), 64'(bus.round_valid), 64'd1);
      check($sformatf("busy r%0d", r), 64'(bus.busy), 64'd1);
      check($sformatf("C r%0d", r), bus.C_out, exp_c);
      check($sformatf("D r%0d", r), bus.D_out, exp_d);
      if (r == stall_at) begin
        bus.round_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check($sformatf("stall idx s%0d", s), 64'(bus.round_idx), 64'(r));
          check($sformatf("stall C s%0d", s), bus.C_out, exp_c);
          check($sformatf("stall D s%0d", s), bus.D_out, exp_d);
        end
        bus.round_ready = 1'b1;
      end
      if (poke_at3 && r == 3) begin
        bus.start   = 1'b1;
        bus.decrypt = ~dec;
        bus.key_c   = 64'hFFFF_0000_FFFF_0000;
        bus.key_d   = 64'h1234_5678_9ABC_DEF0;
      end
      step();
      bus.start = 1'b0;
    end
    check("done pulse", 64'(bus.done), 64'd1);
    check("done busy", 64'(bus.busy), 64'd0);
    check("done valid", 64'(bus.round_valid), 64'd0);
    check("done idx", 64'(bus.round_idx), 64'd0);
  endtask

  initial begin
    Reset           = 1'b1;
    bus.start       = 1'b0;
    bus.decrypt     = 1'b0;
    bus.key_c       = '0;
    bus.key_d       = '0;
    bus.round_ready = 1'b1;
    step();
    step();
    Reset = 1'b0;
    check("rst valid", 64'(bus.round_valid), 64'd0);
    check("rst idx", 64'(bus.round_idx), 64'd0);
    check("rst C", bus.C_out, 64'd0);
    check("rst D", bus.D_out, 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);

    // Encrypt on single-bit key; a foreign start at round 3 must be ignored.
    start_sched(1'b0, 64'h1, 64'h8000_0000_0000_0000);
    check("enc r1 C", bus.C_out, 64'h2);
    check("enc r1 D", bus.D_out, 64'h1);
    run(1'b0, 64'h1, 64'h8000_0000_0000_0000, 0, 1'b1);

    // Start during the done cycle; this run also stalls at round 5.
    start_sched(1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    run(1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5, 1'b0);
    step();
    check("done one cycle", 64'(bus.done), 64'd0);

    // Decrypt order on the single-bit key.
    start_sched(1'b1, 64'h1, 64'h8000_0000_0000_0000);
    check("dec r1 C", bus.C_out, 64'h1000_0000);
    check("dec r1 D", bus.D_out, 64'h0800_0000);
    run(1'b1, 64'h1, 64'h8000_0000_0000_0000, 0, 1'b0);
    step();

    // Reset at round 7 discards the schedule.
    start_sched(1'b0, 64'hA5A5_A5A5_0F0F_0F0F, 64'h3C3C_3C3C_C3C3_C3C3);
    for (int i = 0; i < 6; i++) step();
    check("pre-reset idx", 64'(bus.round_idx), 64'd7);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid rst valid", 64'(bus.round_valid), 64'd0);
    check("mid rst idx", 64'(bus.round_idx), 64'd0);
    check("mid rst C", bus.C_out, 64'd0);
    check("mid rst D", bus.D_out, 64'd0);
    check("mid rst busy", 64'(bus.busy), 64'd0);
    check("mid rst done", 64'(bus.done), 64'd0);
    step();
    start_sched(1'b1, 64'hA5A5_A5A5_0F0F_0F0F, 64'h3C3C_3C3C_C3C3_C3C3);
    run(1'b1, 64'hA5A5_A5A5_0F0F_0F0F, 64'h3C3C_3C3C_C3C3_C3C3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
